// File: rtl/draw_sequencer.sv
// Frame-level initiator for sprite drawers: once per frame tick, serves each
// client in index order through the begin_draw/done handshake and muxes its pixels.
module draw_sequencer #(
  parameter int NUM_CLIENTS = 2,
  parameter int FRAME_DIV   = 833333,
  parameter int TIMEOUT     = 4096
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [4*NUM_CLIENTS-1:0] mv_req,
  output logic [4*NUM_CLIENTS-1:0] movement,
  output logic [NUM_CLIENTS-1:0]   begin_draw,
  input  logic [NUM_CLIENTS-1:0]   done,
  input  logic [8*NUM_CLIENTS-1:0] pix_x,
  input  logic [7*NUM_CLIENTS-1:0] pix_y,
  input  logic [3*NUM_CLIENTS-1:0] pix_color,
  input  logic [NUM_CLIENTS-1:0]   pix_en,
  output logic [7:0]               x,
  output logic [6:0]               y,
  output logic [2:0]               color,
  output logic                     plot,
  output logic                     busy,
  output logic                     frame_done,
  output logic [NUM_CLIENTS-1:0]   timeout_err,
  output logic                     tick_overrun
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IW-1:0] LAST = IW'(NUM_CLIENTS - 1);
  localparam logic [FW-1:0] FDM1 = FW'(FRAME_DIV - 1);
  localparam logic [TW-1:0] TOM1 = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_REL,
    S_END
  } state_t;

  state_t                   state_q;
  logic [IW-1:0]            idx_q;
  logic [TW-1:0]            wcnt_q;
  logic [FW-1:0]            tcnt_q;
  logic [FW-1:0]            tcnt_d;
  logic                     tick;
  logic [4*NUM_CLIENTS-1:0] mov_q;
  logic [NUM_CLIENTS-1:0]   bd_q;
  logic [NUM_CLIENTS-1:0]   terr_q;
  logic                     busy_q;
  logic                     fdone_q;
  logic                     ovr_q;
  logic [7:0]               x_q;
  logic [6:0]               y_q;
  logic [2:0]               col_q;
  logic                     plot_q;

  logic [NUM_CLIENTS-1:0]   idx_oh;
  logic                     wexp;
  logic                     sel_done;
  logic                     sel_en;
  logic [7:0]               sel_x;
  logic [6:0]               sel_y;
  logic [2:0]               sel_col;

  assign tick   = (tcnt_q == FDM1);
  assign wexp   = (wcnt_q == TOM1);
  assign idx_oh = NUM_CLIENTS'(1) << idx_q;

  // Free-running frame divider, wraps at FRAME_DIV-1
  always_comb begin
    tcnt_d = tick ? '0 : tcnt_q + 1'b1;
  end

  // Frame divider register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tcnt_q <= '0;
    else         tcnt_q <= tcnt_d;
  end

  // Select the lanes of the client currently being served
  always_comb begin
    sel_done = 1'b0;
    sel_en   = 1'b0;
    sel_x    = '0;
    sel_y    = '0;
    sel_col  = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_done = done[i];
        sel_en   = pix_en[i];
        sel_x    = pix_x[8*i +: 8];
        sel_y    = pix_y[7*i +: 7];
        sel_col  = pix_color[3*i +: 3];
      end
    end
  end

  // Sequencer FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      mov_q   <= '0;
      bd_q    <= '0;
      terr_q  <= '0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      fdone_q <= 1'b0;
      if (tick && busy_q) ovr_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (tick && enable) begin
            mov_q   <= mv_req;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          bd_q    <= idx_oh;
          wcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (sel_done) begin
            bd_q    <= '0;
            wcnt_q  <= '0;
            state_q <= S_REL;
          end else if (wexp) begin
            bd_q    <= '0;
            terr_q  <= terr_q | idx_oh;
            wcnt_q  <= '0;
            state_q <= S_REL;
          end else begin
            wcnt_q  <= wcnt_q + 1'b1;
          end
        end
        S_REL: begin
          if (!sel_done || wexp) begin
            if (idx_q == LAST) begin
              fdone_q <= 1'b1;
              state_q <= S_END;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_START;
            end
          end else begin
            wcnt_q  <= wcnt_q + 1'b1;
          end
        end
        S_END: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // One-cycle pixel path; coordinates hold outside the draw window
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q    <= '0;
      y_q    <= '0;
      col_q  <= '0;
      plot_q <= 1'b0;
    end else if (state_q == S_WAIT) begin
      x_q    <= sel_x;
      y_q    <= sel_y;
      col_q  <= sel_col;
      plot_q <= sel_en;
    end else begin
      plot_q <= 1'b0;
    end
  end

  assign movement     = mov_q;
  assign begin_draw   = bd_q;
  assign timeout_err  = terr_q;
  assign busy         = busy_q;
  assign frame_done   = fdone_q;
  assign tick_overrun = ovr_q;
  assign x            = x_q;
  assign y            = y_q;
  assign color        = col_q;
  assign plot         = plot_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: model drawers feed a pixel scoreboard,
// plus a second instance with a short timeout and a stuck client.
module tb_draw_sequencer;

  localparam int FD  = 200;
  localparam int TO  = 4096;
  localparam int FD2 = 100;
  localparam int TO2 = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] mv_req = '0;
  logic [1:0] done_i = '0;
  logic [1:0] pen = '0;
  logic [7:0] px [2];
  logic [6:0] py [2];
  logic [2:0] pc [2];

  logic [7:0] movement;
  logic [1:0] bd;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       plot;
  logic       busy;
  logic       fd;
  logic [1:0] terr;
  logic       tovr;

  logic        en2 = 1'b0;
  logic        d2 = 1'b0;
  logic [1:0]  done2;
  logic [15:0] z16 = '0;
  logic [13:0] z14 = '0;
  logic [5:0]  z6 = '0;
  logic [1:0]  z2 = '0;
  logic [7:0]  mov2;
  logic [1:0]  bd2;
  logic [7:0]  x2;
  logic [6:0]  y2;
  logic [2:0]  c2;
  logic        pl2;
  logic        busy2;
  logic        fd2;
  logic [1:0]  te2;
  logic        to2;

  assign done2 = {1'b0, d2};

  int          checks = 0;
  int          errors = 0;
  int          plots = 0;
  int          fds = 0;
  int          mcnt = 0;
  logic [17:0] sb [$];

  draw_sequencer #(
    .NUM_CLIENTS(2), .FRAME_DIV(FD), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .mv_req(mv_req), .movement(movement),
    .begin_draw(bd), .done(done_i),
    .pix_x({px[1], px[0]}), .pix_y({py[1], py[0]}),
    .pix_color({pc[1], pc[0]}), .pix_en(pen),
    .x(x), .y(y), .color(color), .plot(plot),
    .busy(busy), .frame_done(fd),
    .timeout_err(terr), .tick_overrun(tovr)
  );

  draw_sequencer #(
    .NUM_CLIENTS(2), .FRAME_DIV(FD2), .TIMEOUT(TO2)
  ) dut2 (
    .clk(clk), .resetn(resetn), .enable(en2),
    .mv_req(z6[5:0] == 6'd0 ? 8'h5A : 8'h00), .movement(mov2),
    .begin_draw(bd2), .done(done2),
    .pix_x(z16), .pix_y(z14),
    .pix_color(z6), .pix_en(z2),
    .x(x2), .y(y2), .color(c2), .plot(pl2),
    .busy(busy2), .frame_done(fd2),
    .timeout_err(te2), .tick_overrun(to2)
  );

  always #5 clk = ~clk;

  // Reference frame divider for the main instance
  always @(posedge clk or negedge resetn) begin
    if (!resetn) mcnt <= 0;
    else mcnt <= (mcnt == FD - 1) ? 0 : mcnt + 1;
  end

  task automatic monitor();
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        checks++;
        if ($countones(bd) > 1) begin
          errors++;
          $display("FAIL onehot begin_draw=%b", bd);
        end
        if (fd) fds++;
        if (plot) begin
          plots++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL stray_plot x=%0d y=%0d c=%0d", x, y, color);
          end else begin
            e = sb.pop_front();
            if ({x, y, color} !== e) begin
              errors++;
              $display("FAIL pixel got %h want %h", {x, y, color}, e);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_tick();
    int t = 0;
    while (mcnt != FD - 1 && t < 2 * FD) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (mcnt != FD - 1) begin
      errors++;
      $display("FAIL tick_wait got %0d want %0d", mcnt, FD - 1);
    end
  endtask

  task automatic serve(input int i, input int npix, input int hold);
    int t = 0;
    int o = 1 - i;
    while (bd[i] !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bd[i] !== 1'b1) begin
      errors++;
      $display("FAIL serve%0d_start got %b want 1", i, bd[i]);
      return;
    end
    px[o] = 8'hFF;
    py[o] = 7'h7F;
    pc[o] = 3'h7;
    pen[o] = 1'b1;
    for (int p = 0; p < npix; p++) begin
      px[i] = 8'(20 + 40 * i + p % 8);
      py[i] = 7'(10 + 20 * i + p / 8);
      pc[i] = 3'(i + 1);
      pen[i] = 1'b1;
      sb.push_back({px[i], py[i], pc[i]});
      @(negedge clk);
      pen[i] = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    done_i[i] = 1'b1;
    @(negedge clk);
    checks++;
    if (bd !== 2'b00) begin
      errors++;
      $display("FAIL done%0d_drop got %b want 00", i, bd);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (bd !== 2'b00) begin
        errors++;
        $display("FAIL rel%0d_hold got %b want 00", i, bd);
      end
    end
    done_i[i] = 1'b0;
    pen[o] = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({movement, bd, x, y, color, plot, busy, fd, terr, tovr} !== '0) begin
      errors++;
      $display("FAIL reset_out got %h want 0",
               {movement, bd, x, y, color, plot, busy, fd, terr, tovr});
    end
    checks++;
    if ({mov2, bd2, busy2, fd2, te2, to2, pl2} !== '0) begin
      errors++;
      $display("FAIL reset_out2 got %h want 0",
               {mov2, bd2, busy2, fd2, te2, to2, pl2});
    end
    resetn = 1'b1;
  endtask

  task automatic test_nominal();
    plots = 0;
    fds = 0;
    mv_req = 8'h12;
    enable = 1'b1;
    wait_tick();
    @(negedge clk);
    enable = 1'b0;
    mv_req = 8'h00;
    checks++;
    if (bd !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_cyc1 got bd=%b busy=%b want 00/1", bd, busy);
    end
    checks++;
    if (movement !== 8'h12) begin
      errors++;
      $display("FAIL mv_latch got %h want 12", movement);
    end
    @(negedge clk);
    checks++;
    if (bd !== 2'b01) begin
      errors++;
      $display("FAIL start_lat got %b want 01", bd);
    end
    serve(0, 64, 4);
    @(negedge clk);
    checks++;
    if (bd !== 2'b00) begin
      errors++;
      $display("FAIL handoff1 got %b want 00", bd);
    end
    @(negedge clk);
    checks++;
    if (bd !== 2'b10) begin
      errors++;
      $display("FAIL handoff2 got %b want 10", bd);
    end
    checks++;
    if (movement !== 8'h12) begin
      errors++;
      $display("FAIL mv_hold got %h want 12", movement);
    end
    serve(1, 64, 0);
    @(negedge clk);
    checks++;
    if (fd !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fend got fd=%b busy=%b want 1/1", fd, busy);
    end
    @(negedge clk);
    checks++;
    if (fd !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fidle got fd=%b busy=%b want 0/0", fd, busy);
    end
    checks++;
    if (plots != 128 || sb.size() != 0) begin
      errors++;
      $display("FAIL plot_count got %0d/%0d want 128/0", plots, sb.size());
    end
    checks++;
    if (fds != 1) begin
      errors++;
      $display("FAIL fd_count got %0d want 1", fds);
    end
    checks++;
    if (tovr !== 1'b1 || terr !== 2'b00) begin
      errors++;
      $display("FAIL overrun got ovr=%b err=%b want 1/00", tovr, terr);
    end
  endtask

  task automatic test_enable();
    int f0;
    enable = 1'b0;
    mv_req = 8'h34;
    wait_tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bd !== 2'b00) begin
        errors++;
        $display("FAIL en0 got busy=%b bd=%b want 0/00", busy, bd);
      end
    end
    checks++;
    if (movement !== 8'h12) begin
      errors++;
      $display("FAIL en0_mv got %h want 12", movement);
    end
    enable = 1'b1;
    wait_tick();
    @(negedge clk);
    enable = 1'b0;
    checks++;
    if (movement !== 8'h34 || busy !== 1'b1) begin
      errors++;
      $display("FAIL en1 got mv=%h busy=%b want 34/1", movement, busy);
    end
    @(negedge clk);
    checks++;
    if (bd !== 2'b01) begin
      errors++;
      $display("FAIL en1_bd got %b want 01", bd);
    end
    f0 = fds;
    serve(0, 2, 0);
    serve(1, 2, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (fds != f0 + 1) begin
      errors++;
      $display("FAIL en1_fd got %0d want %0d", fds, f0 + 1);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    mv_req = 8'h56;
    wait_tick();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    px[0] = 8'd1;
    py[0] = 7'd2;
    pc[0] = 3'd3;
    pen[0] = 1'b1;
    sb.push_back({px[0], py[0], pc[0]});
    @(negedge clk);
    px[0] = 8'd4;
    sb.push_back({px[0], py[0], pc[0]});
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (bd !== 2'b00 || plot !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got bd=%b plot=%b want 00/0", bd, plot);
    end
    sb.delete();
    pen[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({movement, bd, x, y, color, plot, busy, fd, terr, tovr} !== '0) begin
      errors++;
      $display("FAIL rst_vals got %h want 0",
               {movement, bd, x, y, color, plot, busy, fd, terr, tovr});
    end
    resetn = 1'b1;
    enable = 1'b1;
    wait_tick();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bd !== 2'b01) begin
      errors++;
      $display("FAIL rst_restart got %b want 01", bd);
    end
    serve(0, 3, 0);
    serve(1, 3, 0);
    @(negedge clk);
    checks++;
    if (fd !== 1'b1) begin
      errors++;
      $display("FAIL rst_fd got %b want 1", fd);
    end
  endtask

  task automatic test_stuck();
    int t = 0;
    en2 = 1'b1;
    while (bd2[0] !== 1'b1 && t < 3 * FD2) begin
      @(negedge clk);
      t++;
    end
    en2 = 1'b0;
    checks++;
    if (bd2 !== 2'b01) begin
      errors++;
      $display("FAIL stuck_c0 got %b want 01", bd2);
    end
    d2 = 1'b1;
    @(negedge clk);
    d2 = 1'b0;
    checks++;
    if (bd2 !== 2'b00) begin
      errors++;
      $display("FAIL stuck_c0drop got %b want 00", bd2);
    end
    t = 0;
    while (bd2[1] !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bd2 !== 2'b10) begin
      errors++;
      $display("FAIL stuck_c1 got %b want 10", bd2);
    end
    t = 0;
    while (bd2[1] === 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t != TO2) begin
      errors++;
      $display("FAIL stuck_len got %0d want %0d", t, TO2);
    end
    checks++;
    if (te2 !== 2'b10 || to2 !== 1'b0) begin
      errors++;
      $display("FAIL stuck_err got %b/%b want 10/0", te2, to2);
    end
    @(negedge clk);
    checks++;
    if (fd2 !== 1'b1) begin
      errors++;
      $display("FAIL stuck_fd got %b want 1", fd2);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      px[i] = '0;
      py[i] = '0;
      pc[i] = '0;
    end
    fork
      monitor();
    join_none
    test_reset();
    test_nominal();
    test_enable();
    test_reset_mid();
    test_stuck();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Frame-level initiator for the sprite drawers' `begin_draw`/`done` handshake. Once per frame tick it walks every client drawer in index order: latch its movement request, raise its `begin_draw`, forward its pixel stream to the VGA adapter, wait for `done`, then release. It sits between the game-control logic and the VGA adapter and is the only block that drives the adapter's plot port.

## Interface
Parameters:
- `NUM_CLIENTS`, 2: number of drawer clients; index 0 is served first.
- `FRAME_DIV`, 833333: clocks per frame tick (50 MHz / 60 Hz).
- `TIMEOUT`, 4096: maximum clocks spent in either wait state per client.

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: when 0, no new frame is started; a frame already in progress completes.
- `mv_req` in 4*NUM_CLIENTS: movement request per client; 4 bits per client, client i in bits [4i+3:4i].
- `movement` out 4*NUM_CLIENTS: latched movement, stable for the whole frame.
- `begin_draw` out NUM_CLIENTS: per-client draw request.
- `done` in NUM_CLIENTS: per-client done.
- `pix_x` in 8*NUM_CLIENTS: per-client pixel x coordinate.
- `pix_y` in 7*NUM_CLIENTS: per-client pixel y coordinate.
- `pix_color` in 3*NUM_CLIENTS: per-client pixel colour.
- `pix_en` in NUM_CLIENTS: per-client draw enable.
- `x` out 8, `y` out 7, `color` out 3, `plot` out 1: outputs to the VGA adapter.
- `busy` out 1: high from frame start through FRAME_END inclusive.
- `frame_done` out 1: one-cycle pulse when the last client is released.
- `timeout_err` out NUM_CLIENTS: sticky; bit i is set when client i times out.
- `tick_overrun` out 1: sticky; set when a tick arrives while `busy` is high.

## Operation
- Reset values: all outputs 0; state IDLE; client index 0; tick counter 0.
- Tick counter: free-running from 0 to FRAME_DIV-1, then wraps. `tick` is high for one cycle when count == FRAME_DIV-1. The counter runs regardless of `enable` or state.
- States:
  - IDLE: on `tick` with `enable` high, latch `mv_req` into `movement`, set idx=0, set `busy`=1, go to START.
  - START: `begin_draw[idx]`=1, clear the wait counter, go to WAIT_DONE.
  - WAIT_DONE: hold `begin_draw[idx]`. Forward client idx's pixels.
    - If `done[idx]`=1: drop `begin_draw[idx]` and go to RELEASE.
    - Else if the wait counter reaches TIMEOUT-1: drop `begin_draw[idx]`, set `timeout_err[idx]`, go to RELEASE.
  - RELEASE: wait for `done[idx]`=0, or for TIMEOUT clocks. Then, if idx==NUM_CLIENTS-1, go to FRAME_END; otherwise idx+1 and go to START. The wait counter restarts on entry.
  - FRAME_END: pulse `frame_done`, clear `busy`, go to IDLE.
- At most one `begin_draw` bit is high at any time. No client is started while a previous client's `done` is still high, except after a RELEASE timeout.
- Pixel mux:
  - In WAIT_DONE only: `x`/`y`/`color`/`plot` are registered copies of client idx's `pix_x`/`pix_y`/`pix_color`/`pix_en`.
  - In every other state: `plot` is registered as 0, and `x`/`y`/`color` hold their last values.
- Overrun: a `tick` while `busy`=1 is discarded and sets `tick_overrun`. It never restarts or aborts the current frame.
- `enable` dropping mid-frame has no effect until IDLE.
- Sticky flags clear only on reset.

## Timing
- Tick to `begin_draw[0]` high: 2 cycles (IDLE→START, START registers the output).
- `movement` updates on the cycle after the tick and is constant until the next accepted tick.
- Pixel path latency: exactly 1 clock. x, y, color and plot are delayed equally, so they stay aligned.
- `done[idx]` seen high at edge n: `begin_draw[idx]` is low after edge n. The next client's `begin_draw` rises no earlier than 2 edges after `done[idx]` is seen low.
- Per-client overhead: 3 cycles (START, RELEASE minimum, plus the handoff cycle) on top of the client's draw time.
- Simultaneous `done[idx]` and timeout expiry in WAIT_DONE: `done` wins and no error is flagged.
- Async reset mid-frame: every `begin_draw` bit drops immediately, `plot`=0, and the sequencer returns to IDLE. Clients see `begin_draw` low and return to their own idle state.

## Test plan
- Nominal frame: FRAME_DIV=200, two model drawers with 8x8 sprites (about 192 cycles each), TIMEOUT=4096 → `begin_draw[0]` rises 2 cycles after the tick. `begin_draw[1]` rises only after `done[0]` falls. Exactly 64 distinct (x,y) plots per client reach the output. `frame_done` pulses once.
- Movement latch: `mv_req`=8'h12 at the tick, changed to 8'h00 during the frame → `movement` stays 8'h12 until the next accepted tick.
- Stuck client: `done[1]` tied low, TIMEOUT=16 → `begin_draw[1]` drops 16 cycles after it rose, `timeout_err`=2'b10, and `frame_done` still pulses.
- Overrun: FRAME_DIV=100 with a 150-cycle client → `tick_overrun`=1, no `begin_draw` glitch, and the frame completes normally.
- Reset mid-WAIT_DONE: `resetn` low for 3 cycles → `begin_draw`=0 and `plot`=0 within the reset cycle, and all outputs return to their reset values. After release, the next tick starts the frame at client 0.
- `enable`=0 across a tick → `busy` stays 0 and all `begin_draw` bits stay 0. Setting `enable`=1 starts a frame at the next tick.
